// File: rtl/aud_adc_i2s_rx.sv
// aud_adc_i2s_rx
// Purpose: deserializes the codec ADC I2S stream (codec drives BCLK and LRCK)
// into parallel left/right sample pairs and offers each pair downstream over a
// valid/ready handshake. BCLK, LRCK and data are oversampled in the clk domain.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   enable            1 = capture, 0 = receiver parked in IDLE
//   aud_bclk          codec bit clock (asynchronous)
//   aud_adclrck       codec LR clock, 0 = left, 1 = right (asynchronous)
//   aud_adcdat        codec serial data, MSB first (asynchronous)
//   out_left/right    held sample pair
//   out_valid         pair present on out_left/out_right
//   out_ready         consumer takes the pair when out_valid & out_ready
//   overrun           1-cycle pulse, completed pair dropped (output still full)
//   frame_err         1-cycle pulse, LRCK changed before a word was complete
module aud_adc_i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

  logic [SYNC_STAGES-1:0] bclkSync_q, lrckSync_q, datSync_q;
  logic                   bclkDly_q, lrckDly_q;
  logic                   bclkS, lrckS, datS;
  logic                   bclkRise, lrckEdge, lastBit, canLoad;
  logic [DATA_W-1:0]      newWord;

  state_t                 state_q;
  logic [CNT_W-1:0]       bitCnt_q;
  logic [DATA_W-2:0]      shift_q;
  logic                   ch_q;
  logic [DATA_W-1:0]      leftHold_q;
  logic                   leftValid_q;
  logic [DATA_W-1:0]      outLeft_q, outRight_q;
  logic                   outValid_q, overrun_q, frameErr_q;

  assign bclkS    = bclkSync_q[SYNC_STAGES-1];
  assign lrckS    = lrckSync_q[SYNC_STAGES-1];
  assign datS     = datSync_q[SYNC_STAGES-1];
  assign bclkRise = bclkS & ~bclkDly_q;
  // lrckDly_q holds the LRCK level seen at the previous BCLK rise, so a change
  // of channel shows up exactly on the first BCLK rise after LRCK moved.
  assign lrckEdge = lrckS ^ lrckDly_q;
  assign newWord  = {shift_q, datS};
  assign lastBit  = (bitCnt_q == CNT_W'(DATA_W - 1));
  assign canLoad  = ~outValid_q | out_ready;

  // Synchronizer chains for the three codec inputs plus the edge-detect flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclkSync_q <= '0;
      lrckSync_q <= '0;
      datSync_q  <= '0;
      bclkDly_q  <= 1'b0;
      lrckDly_q  <= 1'b0;
    end else begin
      bclkSync_q <= {bclkSync_q[SYNC_STAGES-2:0], aud_bclk};
      lrckSync_q <= {lrckSync_q[SYNC_STAGES-2:0], aud_adclrck};
      datSync_q  <= {datSync_q[SYNC_STAGES-2:0], aud_adcdat};
      bclkDly_q  <= bclkS;
      if (bclkRise) lrckDly_q <= lrckS;
    end
  end

  // Receive FSM, word assembly and output handshake.
  // The BCLK rise that reveals an LRCK change carries the previous word's LSB,
  // which is also the I2S one-bit delay slot of the new channel; SKIP therefore
  // only clears the counter and the MSB arrives on the following rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      ch_q        <= 1'b0;
      leftHold_q  <= '0;
      leftValid_q <= 1'b0;
      outLeft_q   <= '0;
      outRight_q  <= '0;
      outValid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
      if (outValid_q && out_ready) outValid_q <= 1'b0;

      if (!enable) begin
        state_q     <= IDLE;
        bitCnt_q    <= '0;
        leftValid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bclkRise && lrckEdge && !lrckS) begin
              state_q     <= SKIP;
              ch_q        <= 1'b0;
              leftValid_q <= 1'b0;
            end
          end
          SKIP: begin
            bitCnt_q <= '0;
            state_q  <= SHIFT;
          end
          SHIFT: begin
            if (bclkRise) begin
              if (lastBit) begin
                // Word complete; a simultaneous LRCK edge is handled after it.
                shift_q  <= newWord[DATA_W-2:0];
                bitCnt_q <= CNT_W'(DATA_W);
                if (!ch_q) begin
                  leftHold_q  <= newWord;
                  leftValid_q <= 1'b1;
                end else begin
                  leftValid_q <= 1'b0;
                  if (leftValid_q) begin
                    if (canLoad) begin
                      outLeft_q  <= leftHold_q;
                      outRight_q <= newWord;
                      outValid_q <= 1'b1;
                    end else begin
                      overrun_q <= 1'b1;
                    end
                  end
                end
                if (lrckEdge) begin
                  state_q <= SKIP;
                  ch_q    <= lrckS;
                end else begin
                  state_q <= WAIT;
                end
              end else if (lrckEdge) begin
                // Short word: drop it and any pending left so pairs never mix.
                frameErr_q  <= 1'b1;
                leftValid_q <= 1'b0;
                state_q     <= SKIP;
                ch_q        <= lrckS;
              end else begin
                shift_q  <= newWord[DATA_W-2:0];
                bitCnt_q <= bitCnt_q + CNT_W'(1);
              end
            end
          end
          WAIT: begin
            if (bclkRise && lrckEdge) begin
              state_q <= SKIP;
              ch_q    <= lrckS;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_left  = outLeft_q;
  assign out_right = outRight_q;
  assign out_valid = outValid_q;
  assign overrun   = overrun_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_aud_adc_i2s_rx.sv
// tb_aud_adc_i2s_rx
// Purpose: directed self-checking bench for aud_adc_i2s_rx. Drives an I2S
// stream with BCLK = clk/8 and 16 BCLKs per channel, records accepted pairs,
// pulses and out_valid timing, and compares against hand-computed values.
module tb_aud_adc_i2s_rx;

  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic              aud_bclk, aud_adclrck, aud_adcdat;
  logic              out_ready;
  logic [DATA_W-1:0] out_left, out_right;
  logic              out_valid, overrun, frame_err;

  int checks = 0;
  int failures = 0;

  int   cycleCnt = 0;
  int   lastRiseCycle = 0;
  int   validRiseCycle = 0;
  int   validCycles = 0;
  int   overrunCnt = 0;
  int   frameErrCnt = 0;
  logic prevValid = 1'b0;
  logic [31:0] pairQ[$];
  logic pendingBit;

  aud_adc_i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .aud_bclk   (aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_adcdat (aud_adcdat),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge; inputs only change just after posedge,
  // so what is seen here is what the next posedge will act on.
  always @(negedge clk) begin
    cycleCnt++;
    if (out_valid === 1'b1 && prevValid !== 1'b1) validRiseCycle = cycleCnt;
    prevValid = out_valid;
    if (out_valid === 1'b1) validCycles++;
    if (out_valid === 1'b1 && out_ready === 1'b1) pairQ.push_back({out_left, out_right});
    if (overrun === 1'b1) overrunCnt++;
    if (frame_err === 1'b1) frameErrCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b0;
    aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
    pendingBit = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
  endtask

  // One BCLK period: LRCK/data change at the falling edge, codec samples on rise.
  task automatic sendSlot(input logic lr, input logic d);
    tick();
    aud_bclk = 1'b0; aud_adclrck = lr; aud_adcdat = d;
    repeat (3) tick();
    tick();
    aud_bclk = 1'b1;
    lastRiseCycle = cycleCnt;
    repeat (3) tick();
  endtask

  // Half frame: first slot carries the previous word's LSB (I2S delay), then
  // n-1 bits of word MSB first; the next bit waits for the next half's slot 0.
  task automatic sendHalf(input logic lr, input logic [15:0] word, input int n);
    sendSlot(lr, pendingBit);
    for (int i = 1; i < n; i++) sendSlot(lr, word[16-i]);
    pendingBit = word[16-n];
  endtask

  task automatic sendFrame(input logic [15:0] l, input logic [15:0] r);
    sendHalf(1'b0, l, 16);
    sendHalf(1'b1, r, 16);
  endtask

  task automatic flush();
    sendSlot(1'b0, pendingBit);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
    aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
    repeat (2) tick();
    checks++; if (out_left !== 16'h0) begin failures++; $display("[TB] FAIL reset_left: got %h expected 0000", out_left); end
    checks++; if (out_right !== 16'h0) begin failures++; $display("[TB] FAIL reset_right: got %h expected 0000", out_right); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_basic_frame();
    int base, vcBase;
    doReset();
    out_ready = 1'b1;
    base = pairQ.size(); vcBase = validCycles;
    sendHalf(1'b1, 16'h0000, 4);
    sendFrame(16'hA5C3, 16'h3C5A);
    flush();
    repeat (4) tick();
    checks++; if (pairQ.size() - base !== 1) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 1", pairQ.size() - base); end
    checks++;
    if (pairQ.size() <= base || pairQ[base] !== 32'hA5C3_3C5A) begin
      failures++; $display("[TB] FAIL basic_pair: got %h expected a5c33c5a", (pairQ.size() > base) ? pairQ[base] : 32'hx);
    end
    // Two synchronizer samples plus the capture edge after a BCLK rise driven
    // just past a posedge: out_valid is first seen SYNC_STAGES+2 negedges later.
    checks++; if (validRiseCycle - lastRiseCycle !== SYNC_STAGES + 2) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected %0d", validRiseCycle - lastRiseCycle, SYNC_STAGES + 2); end
    checks++; if (validCycles - vcBase !== 1) begin failures++; $display("[TB] FAIL basic_valid_len: got %0d expected 1", validCycles - vcBase); end
  endtask

  task automatic test_back_to_back();
    int base, vcBase, ovBase;
    logic [31:0] exp;
    doReset();
    out_ready = 1'b1;
    base = pairQ.size(); vcBase = validCycles; ovBase = overrunCnt;
    sendHalf(1'b1, 16'h0000, 4);
    for (int k = 1; k <= 4; k++) sendFrame(16'(k), 16'(16'h8000 + k));
    flush();
    repeat (4) tick();
    checks++; if (pairQ.size() - base !== 4) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 4", pairQ.size() - base); end
    for (int k = 1; k <= 4; k++) begin
      exp = {16'(k), 16'(16'h8000 + k)};
      checks++;
      if (pairQ.size() < base + k || pairQ[base+k-1] !== exp) begin
        failures++; $display("[TB] FAIL b2b_pair%0d: got %h expected %h", k, (pairQ.size() >= base + k) ? pairQ[base+k-1] : 32'hx, exp);
      end
    end
    checks++; if (validCycles - vcBase !== 4) begin failures++; $display("[TB] FAIL b2b_valid_cycles: got %0d expected 4", validCycles - vcBase); end
    checks++; if (overrunCnt - ovBase !== 0) begin failures++; $display("[TB] FAIL b2b_overrun: got %0d expected 0", overrunCnt - ovBase); end
  endtask

  task automatic test_backpressure();
    int base, ovBase;
    doReset();
    out_ready = 1'b0;
    base = pairQ.size(); ovBase = overrunCnt;
    sendHalf(1'b1, 16'h0000, 4);
    sendFrame(16'h1111, 16'h2222);
    sendFrame(16'h3333, 16'h4444);
    checks++; if (out_left !== 16'h1111) begin failures++; $display("[TB] FAIL bp_left_mid: got %h expected 1111", out_left); end
    flush();
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_held: got %b expected 1", out_valid); end
    checks++; if (out_left !== 16'h1111) begin failures++; $display("[TB] FAIL bp_left_held: got %h expected 1111", out_left); end
    checks++; if (out_right !== 16'h2222) begin failures++; $display("[TB] FAIL bp_right_held: got %h expected 2222", out_right); end
    checks++; if (overrunCnt - ovBase !== 1) begin failures++; $display("[TB] FAIL bp_overrun: got %0d expected 1", overrunCnt - ovBase); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_valid_drop: got %b expected 0", out_valid); end
    checks++;
    if (pairQ.size() - base !== 1 || pairQ[base] !== 32'h1111_2222) begin
      failures++; $display("[TB] FAIL bp_accept: got %0d pairs first %h expected 1 pair 11112222", pairQ.size() - base, (pairQ.size() > base) ? pairQ[base] : 32'hx);
    end
  endtask

  task automatic test_frame_err();
    int base, feBase;
    doReset();
    out_ready = 1'b1;
    base = pairQ.size(); feBase = frameErrCnt;
    sendHalf(1'b1, 16'h0000, 4);
    sendHalf(1'b0, 16'hAAAA, 11);
    sendHalf(1'b1, 16'hBBBB, 16);
    sendFrame(16'h1357, 16'h2468);
    flush();
    repeat (4) tick();
    checks++; if (frameErrCnt - feBase !== 1) begin failures++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", frameErrCnt - feBase); end
    checks++; if (pairQ.size() - base !== 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d expected 1", pairQ.size() - base); end
    checks++;
    if (pairQ.size() <= base || pairQ[base] !== 32'h1357_2468) begin
      failures++; $display("[TB] FAIL ferr_pair: got %h expected 13572468", (pairQ.size() > base) ? pairQ[base] : 32'hx);
    end
  endtask

  task automatic test_reset_mid_word();
    int base;
    out_ready = 1'b1;
    enable = 1'b0; tick(); enable = 1'b1; tick();
    base = pairQ.size();
    sendHalf(1'b1, 16'h0000, 4);
    sendHalf(1'b0, 16'h1234, 16);
    sendHalf(1'b1, 16'h5678, 8);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (out_left !== 16'h0) begin failures++; $display("[TB] FAIL rst_mid_left: got %h expected 0000", out_left); end
    checks++; if (out_right !== 16'h0) begin failures++; $display("[TB] FAIL rst_mid_right: got %h expected 0000", out_right); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid); end
    reset = 1'b0;
    pendingBit = 1'b0;
    tick();
    sendHalf(1'b1, 16'hFFFF, 8);
    sendFrame(16'h7FFF, 16'h8000);
    flush();
    repeat (4) tick();
    checks++; if (pairQ.size() - base !== 1) begin failures++; $display("[TB] FAIL rst_mid_count: got %0d expected 1", pairQ.size() - base); end
    checks++;
    if (pairQ.size() <= base || pairQ[base] !== 32'h7FFF_8000) begin
      failures++; $display("[TB] FAIL rst_mid_pair: got %h expected 7fff8000", (pairQ.size() > base) ? pairQ[base] : 32'hx);
    end
  endtask

  task automatic test_right_first();
    int base;
    doReset();
    out_ready = 1'b1;
    base = pairQ.size();
    sendHalf(1'b1, 16'hBEEF, 16);
    sendFrame(16'h1234, 16'h5678);
    flush();
    repeat (4) tick();
    checks++; if (pairQ.size() - base !== 1) begin failures++; $display("[TB] FAIL rfirst_count: got %0d expected 1", pairQ.size() - base); end
    checks++;
    if (pairQ.size() <= base || pairQ[base] !== 32'h1234_5678) begin
      failures++; $display("[TB] FAIL rfirst_pair: got %h expected 12345678", (pairQ.size() > base) ? pairQ[base] : 32'hx);
    end
  endtask

  // Scenario sequence; the frame-error test deliberately leaves a held pair so
  // the mid-word reset test can see reset clear non-zero outputs.
  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
    aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
    pendingBit = 1'b0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_backpressure();
    test_frame_err();
    test_reset_mid_word();
    test_right_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
